// File: rtl/insn_boot_loader_pkg.sv
// Shared constants for the instruction boot loader.
// FSM encoding and default frame/memory parameters.
package insn_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MEM_WORDS_DEF = 1024;
  localparam int         ADDR_W_DEF    = 10;

  localparam logic [2:0] ST_WAIT_SYNC = 3'd0;
  localparam logic [2:0] ST_LEN_LO    = 3'd1;
  localparam logic [2:0] ST_LEN_HI    = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_CHECK     = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

endpackage

// File: rtl/boot_word_assembler.sv
// Little-endian byte-to-word assembler for the boot loader.
// Emits a combinational word_done on the 4th byte of each word.
module boot_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] shreg;

  assign word      = {byte_data, shreg};
  assign word_done = byte_valid && (idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= 2'd0;
      shreg <= 24'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      shreg <= 24'd0;
    end else if (byte_valid) begin
      idx   <= idx + 2'd1;
      shreg <= word[31:8];
    end
  end

endmodule

// File: rtl/insn_boot_loader.sv
// Serial boot loader: parses a framed image into instruction memory
// and releases the core from reset once the checksum verifies.
module insn_boot_loader
  import insn_boot_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MEM_WORDS = MEM_WORDS_DEF,
  parameter int         ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset_n,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAX_LEN = 17'(MEM_WORDS);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   len_full;
  logic [ADDR_W:0] word_cnt;
  logic [15:0]   cnt_inc;
  logic [7:0]    csum;
  logic          acc;
  logic          is_sync;
  logic          asm_clear;
  logic          asm_valid;
  logic          word_done;
  logic [31:0]   word;

  assign rx_ready  = (state != ST_DONE);
  assign acc       = rx_valid && rx_ready;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign len_full  = {rx_data, len_lo};
  assign cnt_inc   = 16'(word_cnt) + 16'd1;
  assign asm_valid = acc && (state == ST_DATA);

  boot_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word_done  (word_done),
    .word       (word)
  );

  always_comb begin
    state_n   = state;
    asm_clear = 1'b0;
    if (acc) begin
      unique case (state)
        ST_WAIT_SYNC, ST_ERROR: begin
          if (is_sync) begin
            state_n   = ST_LEN_LO;
            asm_clear = 1'b1;
          end
        end
        ST_LEN_LO: state_n = ST_LEN_HI;
        ST_LEN_HI: begin
          if ({1'b0, len_full} > MAX_LEN)
            state_n = ST_ERROR;
          else if (len_full == 16'd0)
            state_n = ST_CHECK;
          else
            state_n = ST_DATA;
        end
        ST_DATA: begin
          if (word_done && (cnt_inc == len))
            state_n = ST_CHECK;
        end
        ST_CHECK: begin
          state_n = (rx_data == csum) ? ST_DONE : ST_ERROR;
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_WAIT_SYNC;
      len_lo       <= 8'd0;
      len          <= 16'd0;
      word_cnt     <= '0;
      csum         <= 8'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      core_reset_n <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      mem_we       <= word_done;
      done         <= (state_n == ST_DONE);
      core_reset_n <= (state_n == ST_DONE);
      error        <= (state_n == ST_ERROR);
      if (acc && (state == ST_LEN_LO))
        len_lo <= rx_data;
      if (acc && (state == ST_LEN_HI))
        len <= len_full;
      if (asm_clear) begin
        word_cnt <= '0;
        csum     <= 8'd0;
      end else begin
        if (asm_valid)
          csum <= csum ^ rx_data;
        if (word_done)
          word_cnt <= word_cnt + 1'b1;
      end
      if (word_done) begin
        mem_addr  <= word_cnt[ADDR_W-1:0];
        mem_wdata <= word;
      end
    end
  end

endmodule
